// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared Pcsrc encodings, FSM states and defaults for the fetch unit
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JR  = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } fetch_state_t;

    // Sign-extended branch immediate, already scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ready bus
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - combinational next-PC selection and jr alignment check
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic        unused_opcode;

    assign seq_pc        = pc + 32'd4;
    assign unused_opcode = ^inst[31:26];

    always_comb begin
        next_pc    = seq_pc;
        misaligned = 1'b0;
        case (pcsrc)
            PC_SEQ: next_pc = seq_pc;
            PC_JR: begin
                next_pc    = rs_data;
                misaligned = (rs_data[1:0] != 2'b00);
            end
            PC_BR:  next_pc = seq_pc + branch_offset(inst[15:0]);
            PC_JMP: next_pc = {seq_pc[31:28], inst[25:0], 2'b00};
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction fetch FSM and instruction register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        inst,
    output logic [5:0]         op,
    output logic [5:0]         func,
    output logic               inst_valid,
    input  logic               commit,
    input  logic [1:0]         pcsrc,
    input  logic [31:0]        rs_data,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fault
);

    fetch_state_t state, state_next;
    logic         pc_load;
    logic         inst_load;
    logic         fault_set;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc_calc (
        .pc         (pc),
        .inst       (inst),
        .pcsrc      (pcsrc),
        .rs_data    (rs_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= 32'h0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            if (pc_load)   pc    <= next_pc;
            if (inst_load) inst  <= imem.rdata;
            if (fault_set) fault <= 1'b1;
        end
    end

    // A misaligned jr wins over halt: PC is left pointing at the faulting jr.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        inst_load  = 1'b0;
        fault_set  = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imem.ready) begin
                    inst_load  = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    if (misaligned) begin
                        fault_set  = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_load    = 1'b1;
                        state_next = halt ? HALT : FETCH;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign imem.req   = (state == FETCH);
    assign imem.addr  = pc;
    assign inst_valid = (state == EXEC);
    assign pc_plus4   = pc + 32'd4;
    assign op         = inst[31:26];
    assign func       = inst[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] word;
        int          waits;
        logic [1:0]  src;
        logic [31:0] rs;
        logic [31:0] exp_next;
        logic [31:0] exp_plus4;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        inst_valid;
    logic        commit;
    logic [1:0]  pcsrc;
    logic [31:0] rs_data;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus),
        .inst       (inst),
        .op         (op),
        .func       (func),
        .inst_valid (inst_valid),
        .commit     (commit),
        .pcsrc      (pcsrc),
        .rs_data    (rs_data),
        .halt       (halt),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fault      (fault)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];
    vec_t tbl[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input int waits, input logic [31:0] word);
        int n;
        logic [31:0] exp_addr;
        n = 0;
        while (!bus.req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'b0, bus.req}, 32'd1);
        if (sb.size() > 0) begin
            exp_addr = sb.pop_front();
        end else begin
            exp_addr = 32'hBAAD_F00D;
            chk("sb_empty", 32'd0, 32'd1);
        end
        chk("fetch_addr", bus.addr, exp_addr);
        chk("fetch_pc", pc, exp_addr);
        chk("valid_low_in_fetch", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            bus.ready = 1'b0;
            bus.rdata = $urandom;
            @(negedge clk);
            chk("wait_req", {31'b0, bus.req}, 32'd1);
            chk("wait_addr", bus.addr, exp_addr);
            chk("wait_valid", {31'b0, inst_valid}, 32'd0);
        end
        bus.ready = 1'b1;
        bus.rdata = word;
        @(negedge clk);
        bus.ready = 1'b0;
        bus.rdata = $urandom;
        chk("capture_valid", {31'b0, inst_valid}, 32'd1);
        chk("capture_req", {31'b0, bus.req}, 32'd0);
        chk("capture_inst", inst, word);
        chk("capture_op", {26'b0, op}, {26'b0, word[31:26]});
        chk("capture_func", {26'b0, func}, {26'b0, word[5:0]});
    endtask

    task automatic do_commit(input logic [1:0] src, input logic [31:0] rs, input logic hlt,
                             input logic [31:0] exp_next, input logic exp_fault);
        chk("commit_valid", {31'b0, inst_valid}, 32'd1);
        commit  = 1'b1;
        pcsrc   = src;
        rs_data = rs;
        halt    = hlt;
        @(negedge clk);
        commit  = 1'b0;
        halt    = 1'b0;
        pcsrc   = 2'($urandom);
        rs_data = $urandom;
        if (!exp_fault && !hlt) sb.push_back(exp_next);
        chk("commit_pc", pc, exp_next);
        chk("commit_fault", {31'b0, fault}, {31'b0, exp_fault});
        chk("commit_valid_low", {31'b0, inst_valid}, 32'd0);
        chk("commit_req", {31'b0, bus.req}, {31'b0, !(hlt || exp_fault)});
    endtask

    task automatic halted_pulses(input logic [31:0] exp_pc, input logic exp_fault);
        for (int i = 0; i < 3; i++) begin
            commit    = 1'b1;
            pcsrc     = 2'($urandom);
            rs_data   = $urandom;
            bus.ready = 1'b1;
            @(negedge clk);
            chk("halt_req", {31'b0, bus.req}, 32'd0);
            chk("halt_valid", {31'b0, inst_valid}, 32'd0);
            chk("halt_pc", pc, exp_pc);
            chk("halt_fault", {31'b0, fault}, {31'b0, exp_fault});
        end
        commit    = 1'b0;
        bus.ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0020, 0, PC_SEQ, 32'h0,         32'h0000_0004, 32'h0000_0004};
        tbl[1]  = '{32'h0000_0022, 0, PC_SEQ, 32'h0,         32'h0000_0008, 32'h0000_0008};
        tbl[2]  = '{32'h0000_0024, 0, PC_SEQ, 32'h0,         32'h0000_000C, 32'h0000_000C};
        tbl[3]  = '{32'h0000_0025, 0, PC_SEQ, 32'h0,         32'h0000_0010, 32'h0000_0010};
        tbl[4]  = '{32'h0800_0040, 3, PC_JMP, 32'h0,         32'h0000_0100, 32'h0000_0014};
        tbl[5]  = '{32'h1000_FFFE, 0, PC_BR,  32'h0,         32'h0000_00FC, 32'h0000_0104};
        tbl[6]  = '{32'h0000_0008, 0, PC_JR,  32'h0000_3008, 32'h0000_3008, 32'h0000_0100};
        tbl[7]  = '{32'h0C00_0C00, 0, PC_JMP, 32'h0,         32'h0000_3000, 32'h0000_300C};
        tbl[8]  = '{32'h0000_0008, 1, PC_JR,  32'h0000_0100, 32'h0000_0100, 32'h0000_3004};
        tbl[9]  = '{32'h1000_0003, 0, PC_BR,  32'h0,         32'h0000_0110, 32'h0000_0104};
        tbl[10] = '{32'h0000_0008, 2, PC_JR,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0114};
        tbl[11] = '{32'h0000_0020, 0, PC_SEQ, 32'h0,         32'h0000_0000, 32'h0000_0000};
        tbl[12] = '{32'h1000_8000, 0, PC_BR,  32'h0,         32'hFFFE_0004, 32'h0000_0004};
        tbl[13] = '{32'h0000_0008, 0, PC_JR,  32'h0000_2000, 32'h0000_2000, 32'hFFFE_0008};

        rst_n     = 1'b0;
        commit    = 1'b0;
        pcsrc     = PC_SEQ;
        rs_data   = 32'h0;
        halt      = 1'b0;
        bus.ready = 1'b0;
        bus.rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_inst", inst, 32'h0);
        chk("rst_op_func", {20'b0, op, func}, 32'h0);
        chk("rst_req", {31'b0, bus.req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'b0, bus.req}, 32'd1);
        sb.push_back(32'h0);

        for (int i = 0; i < 14; i++) begin
            do_fetch(tbl[i].waits, tbl[i].word);
            chk("exec_pc_plus4", pc_plus4, tbl[i].exp_plus4);
            do_commit(tbl[i].src, tbl[i].rs, 1'b0, tbl[i].exp_next, 1'b0);
        end

        // Misaligned jr at 0x2000: fault, PC frozen, later commits ignored.
        do_fetch(0, 32'h0000_0008);
        do_commit(PC_JR, 32'h0000_2002, 1'b1, 32'h0000_2000, 1'b1);
        halted_pulses(32'h0000_2000, 1'b1);

        // Reset asserted mid-wait abandons the fetch at 0x4.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sb.push_back(32'h0);
        do_fetch(0, 32'h0000_0020);
        do_commit(PC_SEQ, 32'h0, 1'b0, 32'h0000_0004, 1'b0);
        bus.ready = 1'b0;
        @(negedge clk);
        chk("midrst_req_before", {31'b0, bus.req}, 32'd1);
        chk("midrst_addr_before", bus.addr, 32'h4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, bus.req}, 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_pc_plus4", pc_plus4, 32'h4);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(32'h0);
        do_fetch(1, 32'h0000_0008);

        // Halt at 0x20: PC advances, no fault, no further requests.
        do_commit(PC_JR, 32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0);
        do_fetch(0, 32'h0000_000C);
        do_commit(PC_SEQ, 32'h0, 1'b1, 32'h0000_0024, 1'b0);
        halted_pulses(32'h0000_0024, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
